// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for the two-port Flash bus arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    RELEASE   = 2'd2,
    ACK       = 2'd3
  } state_t;

  localparam int ADDR_W_DEF         = 8;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1023;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker: on contention the port that did not win last time is chosen.
module flash_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 & req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one Flash bus-interface block between two requesters with a 4-phase handshake.
// Optional per-transaction timeout is enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              rw0,
  input  logic              rw1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              fb_dir_rw,
  output logic              fb_start,
  input  logic              fb_done,
  input  logic [DATA_W-1:0] fb_rdata
);

  state_t state, state_nx;
  logic   last_grant;
  logic   gnt_q;
  logic   gnt_valid, gnt_id;
  logic   grant_ok;
  logic   to_hit;

  flash_arb_rr u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] to_cnt;
  logic       done_stale;
  logic       to_take;

  assign to_hit   = (to_cnt == TO_LAST);
  // After an abort with fb_done still high, hold off the next start until Flash releases it.
  assign grant_ok = gnt_valid & ~(done_stale & fb_done);
  assign to_take  = to_hit & (((state == WAIT_DONE) & ~fb_done) | ((state == RELEASE) & fb_done));

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      to_cnt     <= '0;
      done_stale <= 1'b0;
    end else begin
      if (state == IDLE && grant_ok)
        to_cnt <= '0;
      else if ((state == WAIT_DONE || state == RELEASE) && !to_hit)
        to_cnt <= to_cnt + 10'd1;
      if (to_take)
        done_stale <= fb_done;
      else if (!fb_done)
        done_stale <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign to_hit     = 1'b0;
  assign grant_ok   = gnt_valid;
`endif

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (grant_ok)           state_nx = WAIT_DONE;
      WAIT_DONE: if (fb_done)            state_nx = RELEASE;
                 else if (to_hit)        state_nx = ACK;
      RELEASE:   if (!fb_done || to_hit) state_nx = ACK;
      ACK:                               state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Registered outputs; each branch mirrors the transition taken in the next-state logic.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_dir_rw  <= 1'b0;
      fb_start   <= 1'b0;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_ok) begin
          gnt_q      <= gnt_id;
          last_grant <= gnt_id;
          fb_addr    <= gnt_id ? addr1  : addr0;
          fb_wdata   <= gnt_id ? wdata1 : wdata0;
          fb_dir_rw  <= gnt_id ? rw1    : rw0;
          fb_start   <= 1'b1;
          busy       <= 1'b1;
        end
        WAIT_DONE: if (fb_done) begin
          if (fb_dir_rw == RW_READ) rdata <= fb_rdata;
          fb_start <= 1'b0;
        end else if (to_hit) begin
          fb_start <= 1'b0;
          err      <= 1'b1;
          ack0     <= ~gnt_q;
          ack1     <= gnt_q;
        end
        RELEASE: if (!fb_done || to_hit) begin
          // Leaving with fb_done still high can only be a timeout.
          err  <= fb_done;
          ack0 <= ~gnt_q;
          ack1 <= gnt_q;
        end
        ACK: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: vector table of single transactions plus reset, round-robin and timeout sequences.
module tb_flash_arbiter;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, err, busy, fb_dir_rw, fb_start;
  logic [7:0] rdata, fb_addr, fb_wdata;
  logic       fb_done;
  logic [7:0] fb_rdata;

  int checks = 0;
  int failures = 0;

  flash_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_50MHZ(clk), .RST(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .rw0(rw0), .rw1(rw1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_dir_rw(fb_dir_rw),
    .fb_start(fb_start), .fb_done(fb_done), .fb_rdata(fb_rdata)
  );

  always #10 clk = ~clk;

  // Flash model: raises fb_done fl_delay cycles after fb_start, drops it one cycle after fb_start falls.
  int         fl_delay = 3;
  logic       fl_hang = 1'b0;
  logic [7:0] fl_data = 8'h00;
  int         fl_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_done  <= 1'b0;
      fb_rdata <= 8'h00;
      fl_cnt   <= 0;
    end else if (!fb_start) begin
      fb_done <= 1'b0;
      fl_cnt  <= 0;
    end else if (!fb_done && !fl_hang) begin
      if (fl_cnt >= fl_delay - 1) begin
        fb_done  <= 1'b1;
        fb_rdata <= fl_data;
      end else begin
        fl_cnt <= fl_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Protocol monitors
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (fb_start && !prev_start) chk("start_while_done", {31'b0, fb_done}, 32'd0);
    if (ack0 || ack1)            chk("ack_overlap", {31'b0, ack0 & ack1}, 32'd0);
    prev_start = fb_start;
  end

  task automatic run_txn(input int p, input logic [7:0] a, input logic [7:0] wd, input logic rw,
                         output int lat, output int width, output int start_cyc,
                         output logic [7:0] s_addr, output logic [7:0] s_wdata,
                         output logic s_dir, output logic s_err, output logic other_ack);
    logic seen;
    seen = 0; lat = -1; width = 0; start_cyc = 0; other_ack = 0;
    s_addr = 0; s_wdata = 0; s_dir = 0; s_err = 0;
    @(negedge clk);
    if (p == 0) begin req0 = 1; addr0 = a; wdata0 = wd; rw0 = rw; end
    else        begin req1 = 1; addr1 = a; wdata1 = wd; rw1 = rw; end
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (fb_start) start_cyc++;
      if (fb_start && !seen) begin
        seen = 1; s_addr = fb_addr; s_wdata = fb_wdata; s_dir = fb_dir_rw;
      end
      if ((p == 0) ? ack1 : ack0) other_ack = 1;
      if ((p == 0) ? ack0 : ack1) begin
        lat = i - 1; s_err = err;
        break;
      end
    end
    if (p == 0) req0 = 0; else req1 = 0;
    if (lat >= 0) begin
      width = 1;
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) width++;
    end
  endtask

  typedef struct {
    int         port;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rw;
    logic [7:0] frd;
    int         dly;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  int lat, width, scyc;
  logic [7:0] s_addr, s_wdata;
  logic s_dir, s_err, oth;

  initial begin
    vecs[0] = '{0, 8'h35, 8'h00, 1'b1, 8'hC9, 3, 8'hC9, 6};
    vecs[1] = '{1, 8'h10, 8'hA5, 1'b0, 8'h77, 3, 8'hC9, 6};
    vecs[2] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1, 8'h00, 4};
    vecs[3] = '{0, 8'h81, 8'h3C, 1'b0, 8'h11, 2, 8'h00, 5};
    vecs[4] = '{1, 8'h00, 8'hFF, 1'b1, 8'h5A, 1, 8'h5A, 4};

    rst = 1;
    #25;
    chk("rst_fb_start", {31'b0, fb_start}, 0);
    chk("rst_busy",     {31'b0, busy}, 0);
    chk("rst_ack",      {30'b0, ack1, ack0}, 0);
    chk("rst_outputs",  {rdata, fb_addr, fb_wdata, 6'b0, err, fb_dir_rw}, 0);
    @(negedge clk); rst = 0;

    // Reset in the middle of a slow read
    fl_delay = 50;
    @(negedge clk);
    req0 = 1; addr0 = 8'h35; rw0 = 1;
    repeat (3) @(negedge clk);
    chk("pre_rst_start", {31'b0, fb_start}, 1);
    #3 rst = 1; req0 = 0;
    #1;
    chk("midrst_fb_start", {31'b0, fb_start}, 0);
    chk("midrst_busy",     {31'b0, busy}, 0);
    chk("midrst_ack0",     {31'b0, ack0}, 0);
    @(negedge clk); rst = 0;

    foreach (vecs[k]) begin
      fl_delay = vecs[k].dly;
      fl_data  = vecs[k].frd;
      run_txn(vecs[k].port, vecs[k].addr, vecs[k].wdata, vecs[k].rw,
              lat, width, scyc, s_addr, s_wdata, s_dir, s_err, oth);
      chk($sformatf("v%0d_fb_addr", k),  {24'b0, s_addr}, {24'b0, vecs[k].addr});
      chk($sformatf("v%0d_fb_wdata", k), {24'b0, s_wdata}, {24'b0, vecs[k].wdata});
      chk($sformatf("v%0d_fb_dir", k),   {31'b0, s_dir}, {31'b0, vecs[k].rw});
      chk($sformatf("v%0d_latency", k),  lat, vecs[k].exp_lat);
      chk($sformatf("v%0d_ack_width", k), width, 1);
      chk($sformatf("v%0d_start_cyc", k), scyc, vecs[k].dly + 1);
      chk($sformatf("v%0d_err", k),      {31'b0, s_err}, 0);
      chk($sformatf("v%0d_other_ack", k), {31'b0, oth}, 0);
      chk($sformatf("v%0d_rdata", k),    {24'b0, rdata}, {24'b0, vecs[k].exp_rd});
      chk($sformatf("v%0d_addr_hold", k), {24'b0, fb_addr}, {24'b0, vecs[k].addr});
      chk($sformatf("v%0d_idle_busy", k), {31'b0, busy}, 0);
    end

    // Both ports contend: expect strict alternation starting with port 0
    begin
      int order[4];
      int n;
      int r0, r1;
      n = 0; r0 = 0; r1 = 0;
      fl_delay = 2;
      @(negedge clk);
      req0 = 1; addr0 = 8'h20; rw0 = 1;
      req1 = 1; addr1 = 8'h40; rw1 = 0; wdata1 = 8'h66;
      for (int i = 0; i < 400 && n < 4; i++) begin
        @(negedge clk);
        if (ack0) begin order[n] = 0; n++; req0 = 0; end
        else if (!req0 && r0 < 1 && !busy) begin req0 = 1; r0++; end
        if (ack1) begin order[n] = 1; n++; req1 = 0; end
        else if (!req1 && r1 < 1 && !busy) begin req1 = 1; r1++; end
      end
      req0 = 0; req1 = 0;
      chk("rr_count", n, 4);
      for (int j = 0; j < 4; j++)
        chk($sformatf("rr_order%0d", j), (j < n) ? order[j] : -1, j % 2);
      repeat (3) @(negedge clk);
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    // Flash never answers: abort after TO cycles, then a normal transaction
    fl_hang = 1;
    run_txn(0, 8'h35, 8'h00, 1'b1, lat, width, scyc, s_addr, s_wdata, s_dir, s_err, oth);
    chk("to_latency", lat, TO);
    chk("to_start_cyc", scyc, TO);
    chk("to_err", {31'b0, s_err}, 1);
    chk("to_rdata_kept", {24'b0, rdata}, 32'h5A);
    chk("to_err_clear", {31'b0, err}, 0);
    fl_hang = 0; fl_delay = 1; fl_data = 8'h3E;
    run_txn(1, 8'h77, 8'h00, 1'b1, lat, width, scyc, s_addr, s_wdata, s_dir, s_err, oth);
    chk("post_to_latency", lat, 4);
    chk("post_to_err", {31'b0, s_err}, 0);
    chk("post_to_rdata", {24'b0, rdata}, 32'h3E);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single Flash bus-interface block between two requesters: port 0 (display/score reader) and port 1 (config/update writer).
- Owns the Flash block's request side: addr, data, direction_rw, fb_start. Consumes its fb_done and read data.
- Serialises transactions with a 4-phase level handshake and round-robin fairness.
- Signals completion to the winning requester with a one-cycle ack.

Parameters:
- ADDR_W, 8, flash address width on both sides
- DATA_W, 8, flash data width on both sides
- TIMEOUT_CYCLES, 1023, max cycles per transaction before abort (used only with FLASH_ARB_TIMEOUT_EN)

Ports:
- CLK_50MHZ  in  1  system clock, 50 MHz
- RST  in  1  asynchronous reset, active-high
- req0, req1  in  1 each  transaction request, held high until the matching ack
- addr0, addr1  in  ADDR_W  request address, stable while req high
- wdata0, wdata1  in  DATA_W  write data, stable while req high
- rw0, rw1  in  1  1=read, 0=write
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result, valid during ack, held until the next capture
- err  out  1  timeout flag, valid during ack
- busy  out  1  high in every state except IDLE
- fb_addr  out  ADDR_W  to Flash addr
- fb_wdata  out  DATA_W  to Flash data
- fb_dir_rw  out  1  to Flash direction_rw
- fb_start  out  1  to Flash fb_start, level
- fb_done  in  1  from Flash, level
- fb_rdata  in  DATA_W  from Flash read data

Behaviour:
- Reset: asynchronous and immediate. All outputs go to 0 (ack0/1, rdata, err, busy, fb_addr, fb_wdata, fb_dir_rw, fb_start). State=IDLE, last_grant=1 so port 0 wins first, timeout count=0.
- Reset mid-transaction drops fb_start at once. No ack is issued.
- States: IDLE, WAIT_DONE, RELEASE, ACK. All outputs are registered.
- IDLE:
  - Samples req0/req1 at the clock edge.
  - If one request is high, that port is granted.
  - If both are high, the port != last_grant is granted, and last_grant is updated to it.
  - On grant, at the same edge: latch fb_addr/fb_wdata/fb_dir_rw from the granted port, set fb_start=1 and busy=1, go to WAIT_DONE.
- WAIT_DONE: on the first edge with fb_done=1, capture rdata<=fb_rdata if read (write leaves rdata unchanged), set fb_start=0, go to RELEASE.
- RELEASE: on the first edge with fb_done=0, go to ACK and assert ack of the granted port for exactly one cycle.
- ACK: the next edge returns to IDLE, with ack=0 and busy=0.
  - The requester must drop req on the edge that ends the ack cycle.
  - IDLE therefore never re-samples a stale req.
- Minimum turnaround is 4 cycles, req sampled to ack high, when fb_done responds in one cycle and falls in one cycle.
- fb_addr, fb_wdata and fb_dir_rw stay stable from grant until the next grant.
- fb_done already high in IDLE is ignored. fb_start never rises again until fb_done has been seen low (RELEASE guarantees this).
- A req from the non-granted port during a transaction is held off. It is served at the next IDLE, with round-robin applied.

Optional Feature:
- FLASH_ARB_TIMEOUT_EN defined:
  - A 10-bit counter clears on grant and increments each cycle in WAIT_DONE and RELEASE.
  - When it reaches TIMEOUT_CYCLES: fb_start=0, go to ACK with err=1, rdata unchanged.
  - If the Flash block still holds fb_done high at that point, the next grant from IDLE waits until fb_done=0 before raising fb_start.
- Undefined: no counter. Waits indefinitely. err is tied 0.

Decomposition:
- Package flash_arb_pkg holds: state encoding (IDLE=2'd0, WAIT_DONE=2'd1, RELEASE=2'd2, ACK=2'd3), ADDR_W/DATA_W defaults, TIMEOUT_CYCLES default, RW_READ=1/RW_WRITE=0 constants.
- Sub-module flash_arb_rr: 2-way round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: gnt_valid, gnt_id. Combinational.

Test Plan:
- Reset pulse during WAIT_DONE (req0, addr0=8'h35, read) -> fb_start, busy, ack0 all 0 immediately; arbiter in IDLE after reset, ready for the next request.
- Single read, port 0: req0=1, addr0=8'h35, rw0=1; Flash model raises fb_done 3 cycles after fb_start with fb_rdata=8'hC9 and drops it 1 cycle after fb_start falls -> fb_addr=8'h35, fb_dir_rw=1; one ack0 pulse; rdata=8'hC9; err=0.
- Single write, port 1: addr1=8'h10, wdata1=8'hA5, rw1=0 -> fb_wdata=8'hA5, fb_dir_rw=0; one ack1 pulse; rdata unchanged.
- Both requesters hold req for 4 transactions -> grant order 0,1,0,1; no ack overlap; fb_start never rises while fb_done=1.
- Flash model with immediate-response fb_done -> ack exactly 4 cycles after req sampled.
- FLASH_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, fb_done never rises -> fb_start falls after 16 cycles; ack0 with err=1; next request is served normally.
